div512: RTL and testbench

DIV512 -- requirements
Module: div512

---
 rtl/div512.sv | 110 +++++++++++
 tb/tb_div512.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div512.sv
// div512: 512-bit by 256-bit unsigned divider using restoring shift-subtract.
// One quotient bit is produced per clock, MSB first. A zero divisor skips the
// iterations and returns q = all ones, r = a[255:0] with dz set.
module div512 (
  input  logic         clk,
  input  logic         rstn,
  input  logic [511:0] a,
  input  logic [255:0] b,
  input  logic         start,
  output logic [511:0] q,
  output logic [255:0] r,
  output logic         done,
  output logic         busy,
  output logic         dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // r_quo starts as the dividend. Each iteration shifts its MSB into the
  // partial remainder and shifts the new quotient bit into its LSB, so after
  // 512 iterations it holds the quotient.
  logic [511:0] r_quo;
  logic [256:0] r_rem;
  logic [255:0] r_div;
  logic [8:0]   r_cnt;
  logic         r_zero;
  logic         r_dz;

  logic         w_accept;
  logic         w_last;
  logic [256:0] w_shift;
  logic [256:0] w_diff;
  logic         w_ge;

  // A new operation may start from IDLE or from the done cycle (FIN).
  assign w_accept = start && ((r_state == IDLE) || (r_state == FIN));

  // A zero divisor spends a single RUN cycle so done lands after edge N+1.
  assign w_last   = r_zero || (r_cnt == 9'd511);

  // Partial remainder shifted left with the next dividend bit.
  assign w_shift  = {r_rem[255:0], r_quo[511]};
  assign w_diff   = w_shift - {1'b0, r_div};
  // r_rem[256] stays 0 because the remainder is always kept below the
  // divisor; folding it in keeps the compare correct should it ever be set.
  assign w_ge     = r_rem[256] | (w_shift >= {1'b0, r_div});

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = FIN;
      FIN:     w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture on acceptance, then one shift-subtract step per RUN cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_quo  <= a;
      r_rem  <= '0;
      r_div  <= b;
      r_cnt  <= '0;
      r_zero <= (b == '0);
      r_dz   <= 1'b0;
    end else if (r_state == RUN) begin
      if (r_zero) begin
        r_quo <= '1;
        r_rem <= {1'b0, r_quo[255:0]};
        r_dz  <= 1'b1;
      end else begin
        r_rem <= w_ge ? w_diff : w_shift;
        r_quo <= {r_quo[510:0], w_ge};
        r_cnt <= r_cnt + 9'd1;
      end
    end
  end

  assign q    = r_quo;
  assign r    = r_rem[255:0];
  assign dz   = r_dz;
  assign done = (r_state == FIN);
  assign busy = (r_state == RUN);

endmodule

// File: tb/tb_div512.sv
// tb_div512: directed bench for div512 with an arithmetic reference model and
// a per-cycle compare process on done/busy/q/r/dz.
module tb_div512;

  logic         clk;
  logic         rstn;
  logic [511:0] a_in;
  logic [255:0] b_in;
  logic         start;
  logic [511:0] q;
  logic [255:0] r;
  logic         done;
  logic         busy;
  logic         dz;

  int n_vec;
  int n_err;
  int cyc;

  div512 dut (
    .clk   (clk),
    .rstn  (rstn),
    .a     (a_in),
    .b     (b_in),
    .start (start),
    .q     (q),
    .r     (r),
    .done  (done),
    .busy  (busy),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic.
  function automatic logic [511:0] ref_q(input logic [511:0] x, input logic [255:0] y);
    if (y == '0) return '1;
    return x / {256'b0, y};
  endfunction

  function automatic logic [255:0] ref_r(input logic [511:0] x, input logic [255:0] y);
    if (y == '0) return x[255:0];
    return 256'(x % {256'b0, y});
  endfunction

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // Behavioural model: an operation accepted at edge E delivers its result
  // in the cycle after edge E+512 (E+1 for a zero divisor) and is busy until
  // then. Acceptance is possible whenever no operation is pending or during
  // the cycle its result is presented.
  logic         m_active;
  int           m_end;
  logic [511:0] m_q;
  logic [255:0] m_r;
  logic         m_dz;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active <= 1'b0;
      m_end    <= 0;
      m_q      <= '0;
      m_r      <= '0;
      m_dz     <= 1'b0;
    end else if (start && (!m_active || (cyc + 1 >= m_end))) begin
      m_active <= 1'b1;
      m_end    <= cyc + 1 + ((b_in == '0) ? 2 : 513);
      m_q      <= ref_q(a_in, b_in);
      m_r      <= ref_r(a_in, b_in);
      m_dz     <= (b_in == '0);
    end else if (m_active && (cyc + 1 >= m_end)) begin
      m_active <= 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic exp_done;
    logic exp_busy;
    exp_done = m_active && (cyc == m_end - 1);
    exp_busy = m_active && (cyc <  m_end - 1);
    chk("done", done, exp_done);
    chk("busy", busy, exp_busy);
    if (!m_active || exp_done) begin
      chk("q", q, m_q);
      chk("r", r, m_r);
      chk("dz", dz, m_dz);
    end else begin
      chk("dz_run", dz, 1'b0);
    end
  end

  // Drive a one-cycle start; operands are scrambled after the accepting edge.
  task automatic issue(input logic [511:0] av, input logic [255:0] bv);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~av;
    b_in  = ~bv;
  endtask

  // Count cycles from the accepting edge until done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL done_timeout: no done within 700 cycles, expected one");
    lat = -1;
  endtask

  task automatic do_op(input logic [511:0] av, input logic [255:0] bv,
                       input int exp_lat, input string tag);
    int lat;
    logic [767:0] rhs;
    issue(av, bv);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_q"}, q, ref_q(av, bv));
    chk({tag, "_r"}, r, ref_r(av, bv));
    chk({tag, "_dz"}, dz, (bv == '0));
    if (bv != '0) begin
      rhs = {256'b0, q} * {512'b0, bv} + {512'b0, r};
      chk({tag, "_identity"}, rhs, {256'b0, av});
      chk({tag, "_r_lt_b"}, (r < bv), 1'b1);
    end
    $display("op %s lat=%0d q=%0h r=%0h dz=%0b", tag, lat, q, r, dz);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $random;
    return v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $random;
    return v;
  endfunction

  initial begin
    logic [511:0] a1;
    logic [255:0] b1;
    int           lat;
    int           n_done;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rstn  = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;

    // Reset state, with start held high to show it is ignored.
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("rst_q", q, 512'd0);
    chk("rst_r", r, 256'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dz", dz, 1'b0);
    start = 1'b0;
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Corner operands with hand-computed results.
    do_op(512'd5, 256'd7, 513, "5_div_7");
    chk("lit_5_7_q", q, 512'd0);
    chk("lit_5_7_r", r, 256'd5);

    do_op({512{1'b1}}, 256'd1, 513, "max_div_1");
    chk("lit_max_q", q, {512{1'b1}});
    chk("lit_max_r", r, 256'd0);

    do_op({256'b0, {256{1'b1}}}, {256{1'b1}}, 513, "b_div_b");
    chk("lit_bb_q", q, 512'd1);
    chk("lit_bb_r", r, 256'd0);

    do_op(512'h1234, 256'd0, 2, "div_zero");
    chk("lit_dz_q", q, {512{1'b1}});
    chk("lit_dz_r", r, 256'h1234);
    chk("lit_dz_dz", dz, 1'b1);
    repeat (5) @(negedge clk);
    chk("dz_hold", dz, 1'b1);

    // Random operands, including a short divisor for a wide quotient.
    for (int k = 0; k < 3; k++) do_op(rnd512(), rnd256(), 513, "random");
    do_op(rnd512(), {192'b0, rnd256() >> 192}, 513, "short_b");

    // A start 100 cycles into a run must not disturb it.
    a1 = rnd512();
    b1 = rnd256();
    issue(a1, b1);
    repeat (100) @(negedge clk);
    a_in  = rnd512();
    b_in  = 256'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat);
    chk("midstart_lat", lat, 413);
    chk("midstart_q", q, ref_q(a1, b1));
    chk("midstart_r", r, ref_r(a1, b1));
    $display("op midstart lat=%0d q=%0h r=%0h", lat, q, r);
    repeat (3) @(negedge clk);

    // Back-to-back: the second start is driven during the first done cycle.
    do_op(rnd512(), rnd256(), 513, "b2b_first");
    do_op(rnd512(), rnd256(), 513, "b2b_second");
    repeat (3) @(negedge clk);

    // Reset 200 cycles into a run aborts it without a done.
    issue(rnd512(), rnd256());
    repeat (200) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_q", q, 512'd0);
    chk("arst_r", r, 256'd0);
    chk("arst_done", done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_dz", dz, 1'b0);
    a_in  = rnd512();
    b_in  = 256'd9;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    #2 rstn = 1'b1;
    n_done = 0;
    repeat (600) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("arst_no_done", n_done, 0);
    $display("op reset_abort done_pulses=%0d", n_done);
    do_op(rnd512(), rnd256(), 513, "after_reset");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
